// File: rtl/qdr_port_switch.sv
// Purpose : hands the single QDR controller request port to one of NUM_CLIENTS sources,
//           draining outstanding reads before ownership moves to the requested client.
// Latency : request path is combinational (zero cycles); sel takes effect one cycle after it
//           is registered, plus the drain time, plus one SWITCH cycle.
// Backpressure: only the owner sees cli_ready, and only while no switch is pending. Reads are
//           also dropped once MAX_OUTSTANDING reads are in flight. Strobes seen with ready low
//           are dropped, not queued.
// Ports   : clk_ram_ctl/rst_n; sel -> owner/switch_busy; per-client packed cli_* request and
//           return strobes; ram_* controller request side plus ram_rd_valid; sticky underflow_err.
module qdr_port_switch #(
  parameter int NUM_CLIENTS     = 2,
  parameter int ADDR_WIDTH      = 18,
  parameter int DATA_WIDTH      = 144,
  parameter int MAX_OUTSTANDING = 15,
  parameter int RESET_OWNER     = 0,
  localparam int SW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk_ram_ctl,
  input  logic                              rst_n,
  input  logic [SW-1:0]                     sel,
  output logic [SW-1:0]                     owner,
  output logic                              switch_busy,
  output logic                              underflow_err,
  input  logic [NUM_CLIENTS-1:0]            cli_wr_en,
  input  logic [NUM_CLIENTS-1:0]            cli_rd_en,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_wr_addr,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_rd_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_wr_data,
  output logic [NUM_CLIENTS-1:0]            cli_ready,
  output logic [NUM_CLIENTS-1:0]            cli_rd_valid,
  output logic                              ram_wr_en,
  output logic                              ram_rd_en,
  output logic [ADDR_WIDTH-1:0]             ram_wr_addr,
  output logic [ADDR_WIDTH-1:0]             ram_rd_addr,
  output logic [DATA_WIDTH-1:0]             ram_wr_data,
  input  logic                              ram_rd_valid
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_SWITCH} state_t;

  localparam logic [SW-1:0] RST_OWN = SW'(RESET_OWNER);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  state_t        state, state_d;
  logic [SW-1:0] sel_ff;
  logic [CW-1:0] rd_cnt;
  logic          sel_valid;
  logic          sel_diff;
  logic          own_ok;
  logic          own_wr_en, own_rd_en;

  // Out-of-range selections are treated as "stay with the current owner".
  assign sel_valid = (32'(sel_ff) < NUM_CLIENTS);
  assign sel_diff  = sel_valid && (sel_ff != owner);
  assign own_ok    = (state == ST_ACTIVE) && !sel_diff;

  assign switch_busy = (state != ST_ACTIVE) || sel_diff;

  always_ff @(posedge clk_ram_ctl or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_ACTIVE;
      owner         <= RST_OWN;
      sel_ff        <= RST_OWN;
      rd_cnt        <= '0;
      underflow_err <= 1'b0;
    end else begin
      state  <= state_d;
      sel_ff <= sel;
      if (state == ST_SWITCH && sel_valid) begin
        owner <= sel_ff;
      end
      // Issue and return in the same cycle cancel out.
      if (ram_rd_en && !ram_rd_valid) begin
        rd_cnt <= rd_cnt + 1'b1;
      end else if (ram_rd_valid && !ram_rd_en) begin
        if (rd_cnt == '0) begin
          underflow_err <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_ACTIVE: if (sel_diff)      state_d = ST_DRAIN;
      ST_DRAIN:  if (rd_cnt == '0)  state_d = ST_SWITCH;
      ST_SWITCH:                    state_d = ST_ACTIVE;
      default:                      state_d = ST_ACTIVE;
    endcase
  end

  // Owner-slice mux; address/data follow the owner regardless of strobes.
  always_comb begin
    cli_ready    = '0;
    cli_rd_valid = '0;
    own_wr_en    = 1'b0;
    own_rd_en    = 1'b0;
    ram_wr_addr  = '0;
    ram_rd_addr  = '0;
    ram_wr_data  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (owner == SW'(i)) begin
        cli_ready[i]    = own_ok;
        cli_rd_valid[i] = ram_rd_valid;
        own_wr_en       = cli_wr_en[i];
        own_rd_en       = cli_rd_en[i];
        ram_wr_addr     = cli_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_rd_addr     = cli_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wr_data     = cli_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ram_wr_en = own_wr_en && own_ok;
  assign ram_rd_en = own_rd_en && own_ok && (rd_cnt != MAX_CNT);

endmodule

// File: tb/tb_qdr_port_switch.sv
module tb_qdr_port_switch;

  localparam int AW = 18;
  localparam int DW = 144;

  logic clk_ram_ctl = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_ram_ctl = ~clk_ram_ctl;

  // Default two-client instance
  logic [0:0]      sel;
  logic [0:0]      owner;
  logic            switch_busy, underflow_err;
  logic [1:0]      cli_wr_en, cli_rd_en, cli_ready, cli_rd_valid;
  logic [2*AW-1:0] cli_wr_addr, cli_rd_addr;
  logic [2*DW-1:0] cli_wr_data;
  logic            ram_wr_en, ram_rd_en, ram_rd_valid;
  logic [AW-1:0]   ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]   ram_wr_data;

  // Three-client instance for invalid-select behaviour
  logic [1:0]  sel3, owner3;
  logic        busy3, uf3;
  logic [2:0]  wr_en3, rd_en3, ready3, rdv3;
  logic [23:0] wr_addr3, rd_addr3, wr_data3;
  logic        ram_wr_en3, ram_rd_en3, ram_rd_valid3;
  logic [7:0]  ram_wr_addr3, ram_rd_addr3, ram_wr_data3;

  int errors = 0;
  int checks = 0;

  qdr_port_switch u_dut (
    .clk_ram_ctl(clk_ram_ctl), .rst_n(rst_n), .sel(sel), .owner(owner),
    .switch_busy(switch_busy), .underflow_err(underflow_err),
    .cli_wr_en(cli_wr_en), .cli_rd_en(cli_rd_en), .cli_wr_addr(cli_wr_addr),
    .cli_rd_addr(cli_rd_addr), .cli_wr_data(cli_wr_data), .cli_ready(cli_ready),
    .cli_rd_valid(cli_rd_valid), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_valid(ram_rd_valid)
  );

  qdr_port_switch #(.NUM_CLIENTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8)) u_dut3 (
    .clk_ram_ctl(clk_ram_ctl), .rst_n(rst_n), .sel(sel3), .owner(owner3),
    .switch_busy(busy3), .underflow_err(uf3),
    .cli_wr_en(wr_en3), .cli_rd_en(rd_en3), .cli_wr_addr(wr_addr3),
    .cli_rd_addr(rd_addr3), .cli_wr_data(wr_data3), .cli_ready(ready3),
    .cli_rd_valid(rdv3), .ram_wr_en(ram_wr_en3), .ram_rd_en(ram_rd_en3),
    .ram_wr_addr(ram_wr_addr3), .ram_rd_addr(ram_rd_addr3), .ram_wr_data(ram_wr_data3),
    .ram_rd_valid(ram_rd_valid3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 settle.
  task automatic tick();
    @(posedge clk_ram_ctl);
    #1;
  endtask

  initial begin
    sel = '0; cli_wr_en = '0; cli_rd_en = '0; ram_rd_valid = 1'b0;
    cli_wr_addr = '0; cli_rd_addr = '0; cli_wr_data = '0;
    sel3 = '0; wr_en3 = '0; rd_en3 = '0; ram_rd_valid3 = 1'b0;
    wr_addr3 = '0; rd_addr3 = '0; wr_data3 = '0;

    // Reset state
    #3;
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(switch_busy), 64'd0);
    chk("rst_uf", 64'(underflow_err), 64'd0);
    chk("rst_ready", 64'(cli_ready), 64'b01);
    chk("rst_wr_en", 64'(ram_wr_en), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Client 0 write passes through in the same cycle; client 1 fields must not leak
    cli_wr_addr[AW-1:0]    = 18'h00010;
    cli_wr_addr[2*AW-1:AW] = 18'h3ffff;
    cli_wr_data[DW-1:0]    = {16'hbeef, 128'h0};
    cli_wr_data[2*DW-1:DW] = '1;
    cli_rd_addr[AW-1:0]    = 18'h00123;
    cli_wr_en = 2'b01;
    #1;
    chk("wr_en_pass", 64'(ram_wr_en), 64'd1);
    chk("wr_addr_pass", 64'(ram_wr_addr), 64'h10);
    chk("wr_data_top", 64'(ram_wr_data[DW-1:128]), 64'hbeef);
    chk("rd_addr_follow", 64'(ram_rd_addr), 64'h123);
    chk("ready_own0", 64'(cli_ready), 64'b01);
    tick();
    cli_wr_en = 2'b00;

    // Three reads from client 0, then request switch to client 1
    cli_rd_en = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_issue0", 64'(ram_rd_en), 64'd1);
      tick();
    end
    cli_rd_en = 2'b00;
    sel = 1'b1;
    #1;
    chk("pre_sel_ff_ready", 64'(cli_ready), 64'b01);
    chk("pre_sel_ff_busy", 64'(switch_busy), 64'd0);
    tick();
    // sel_ff now 1: requests blocked, still owner 0; a client-0 read must be dropped
    cli_rd_en = 2'b01;
    #1;
    chk("selff_ready", 64'(cli_ready), 64'b00);
    chk("selff_busy", 64'(switch_busy), 64'd1);
    chk("selff_rd_drop", 64'(ram_rd_en), 64'd0);
    tick();
    cli_rd_en = 2'b00;
    // DRAIN: three returns route to old owner
    ram_rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_owner", 64'(owner), 64'd0);
      chk("drain_rdv", 64'(cli_rd_valid), 64'b01);
      tick();
    end
    ram_rd_valid = 1'b0;
    #1;
    chk("drain_done_owner", 64'(owner), 64'd0);
    chk("drain_done_busy", 64'(switch_busy), 64'd1);
    tick();
    // SWITCH cycle
    chk("switch_owner", 64'(owner), 64'd0);
    chk("switch_ready", 64'(cli_ready), 64'b00);
    chk("switch_busy", 64'(switch_busy), 64'd1);
    tick();
    chk("new_owner", 64'(owner), 64'd1);
    chk("new_ready", 64'(cli_ready), 64'b10);
    chk("new_busy", 64'(switch_busy), 64'd0);
    chk("no_uf_after_drain", 64'(underflow_err), 64'd0);

    // Outstanding limit: 15 issue, 16th dropped with ready still high
    cli_rd_en = 2'b10;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("rd_issue1", 64'(ram_rd_en), 64'd1);
      tick();
    end
    #1;
    chk("rd16_drop", 64'(ram_rd_en), 64'd0);
    chk("rd16_ready", 64'(cli_ready), 64'b10);
    tick();
    ram_rd_valid = 1'b1;
    #1;
    chk("full_ret_rd", 64'(ram_rd_en), 64'd0);
    chk("full_ret_rdv", 64'(cli_rd_valid), 64'b10);
    tick();
    ram_rd_valid = 1'b0;
    #1;
    chk("rd_after_ret", 64'(ram_rd_en), 64'd1);
    tick();
    // Back to 15; return 10 to reach 5
    cli_rd_en = 2'b00;
    ram_rd_valid = 1'b1;
    repeat (10) tick();
    // Issue and return together at count 5
    cli_rd_en = 2'b10;
    #1;
    chk("same_cyc_rd", 64'(ram_rd_en), 64'd1);
    tick();
    cli_rd_en = 2'b00;
    // Five more returns empty the counter without underflow
    repeat (5) tick();
    ram_rd_valid = 1'b0;
    #1;
    chk("cnt5_no_uf", 64'(underflow_err), 64'd0);
    tick();
    // One extra return with nothing outstanding
    ram_rd_valid = 1'b1;
    tick();
    ram_rd_valid = 1'b0;
    chk("uf_set", 64'(underflow_err), 64'd1);
    repeat (3) tick();
    chk("uf_sticky", 64'(underflow_err), 64'd1);
    // After underflow the counter stays 0: reads still issue freely
    cli_rd_en = 2'b10;
    #1;
    chk("uf_rd_ok", 64'(ram_rd_en), 64'd1);
    cli_rd_en = 2'b00;

    // Three-client instance: invalid select ignored
    sel3 = 2'd3;
    tick();
    tick();
    chk("inv_busy", 64'(busy3), 64'd0);
    chk("inv_owner", 64'(owner3), 64'd0);
    chk("inv_ready", 64'(ready3), 64'b001);
    tick();
    chk("inv_owner_late", 64'(owner3), 64'd0);
    // Valid select to client 2 with nothing outstanding: ACTIVE->DRAIN->SWITCH->ACTIVE
    sel3 = 2'd2;
    tick();
    chk("c3_busy", 64'(busy3), 64'd1);
    tick();
    tick();
    chk("c3_switch_owner", 64'(owner3), 64'd0);
    tick();
    chk("c3_owner", 64'(owner3), 64'd2);
    chk("c3_ready", 64'(ready3), 64'b100);

    // Reset clears sticky error and ownership
    rst_n = 1'b0;
    #1;
    chk("rst_uf_clr", 64'(underflow_err), 64'd0);
    chk("rst_owner_b", 64'(owner), 64'd0);
    chk("rst_owner3", 64'(owner3), 64'd0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qdr_port_switch.md
QDR_PORT_SWITCH -- requirements
Module: qdr_port_switch

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2, number of request sources (index 0 = FIFO path, 1 = BIST by convention).
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, RAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 144, RAM data word width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 15, maximum reads in flight before read issue stalls.
REQ-005 SHALL have parameter RESET_OWNER, default 0, client owning the RAM after reset.
REQ-006 SHALL define SW = max(1, clog2(NUM_CLIENTS)) and CW = clog2(MAX_OUTSTANDING+1) as local widths.
REQ-007 Ports: clk_ram_ctl  in  1  sole clock, all logic rising-edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 sel  in  SW  requested owner index.
REQ-010 owner  out  SW  current owner index.
REQ-011 switch_busy  out  1  high while a switch is pending or in progress.
REQ-012 underflow_err  out  1  sticky; read data returned with no read outstanding.
REQ-013 cli_wr_en / cli_rd_en  in  NUM_CLIENTS  per-client write/read strobes.
REQ-014 cli_wr_addr / cli_rd_addr  in  NUM_CLIENTS*ADDR_WIDTH  packed per-client addresses, client i at slice i.
REQ-015 cli_wr_data  in  NUM_CLIENTS*DATA_WIDTH  packed per-client write data.
REQ-016 cli_ready  out  NUM_CLIENTS  per-client accept; strobes with ready low are dropped.
REQ-017 cli_rd_valid  out  NUM_CLIENTS  per-client read-return strobe.
REQ-018 ram_wr_en, ram_rd_en  out  1 each; ram_wr_addr, ram_rd_addr  out  ADDR_WIDTH; ram_wr_data  out  DATA_WIDTH; controller request side.
REQ-019 ram_rd_valid  in  1  controller read-return strobe; read data is broadcast outside this block.

Function
REQ-020 SHALL register sel into sel_ff (one-cycle delay) before any use; sel_ff >= NUM_CLIENTS SHALL be treated as equal to owner (ignored).
REQ-021 SHALL implement states ACTIVE, DRAIN, SWITCH.
REQ-022 ACTIVE: if sel_ff != owner (valid) -> DRAIN next cycle; else remain.
REQ-023 DRAIN: when outstanding count == 0 -> SWITCH; else remain, regardless of further sel changes.
REQ-024 SWITCH: owner <= sel_ff if valid, else unchanged; -> ACTIVE; occupies exactly one cycle.
REQ-025 cli_ready[i] SHALL be 1 only when state == ACTIVE, i == owner and sel_ff == owner (or invalid); all others 0.
REQ-026 Request path SHALL be combinational (zero latency): ram_wr_en = cli_wr_en[owner] & cli_ready[owner]; ram_rd_en likewise, additionally gated off when registered count == MAX_OUTSTANDING.
REQ-027 Address/data outputs SHALL follow the owner slice combinationally regardless of enables.
REQ-028 Outstanding counter (CW bits): +1 on ram_rd_en, -1 on ram_rd_valid, unchanged when both in same cycle.
REQ-029 ram_rd_valid with count 0 and no same-cycle ram_rd_en: count stays 0, underflow_err set until reset.
REQ-030 cli_rd_valid[owner] = ram_rd_valid; other bits 0; returns during DRAIN route to the old owner.
REQ-031 switch_busy = (state != ACTIVE) | (sel_ff valid & sel_ff != owner).
REQ-032 Writes SHALL NOT be counted; a switch waits only for reads.

Reset
REQ-033 On rst_n low, asynchronously: state=ACTIVE, owner=RESET_OWNER, sel_ff=RESET_OWNER, count=0, underflow_err=0; hence all ram_*_en and cli_rd_valid 0 except owner pass-through after release.
REQ-034 Reset mid-DRAIN SHALL abandon the switch; in-flight returns after release route to RESET_OWNER and may set underflow_err.

Verification
REQ-035 Reset, sel=0, client0 wr_en addr 0x00010 -> same cycle ram_wr_en=1, ram_wr_addr=0x00010; cli_ready=2'b01.
REQ-036 Client0 issues 3 reads, sel->1 -> cli_ready=0 from cycle after sel_ff changes; owner stays 0 until 3 rd_valid seen; SWITCH one cycle; owner=1, cli_ready=2'b10.
REQ-037 MAX_OUTSTANDING=15, 16 back-to-back reads, no returns -> 16th dropped (ram_rd_en=0, cli_ready=1); one return -> next read issues.
REQ-038 Same-cycle ram_rd_en and ram_rd_valid at count 5 -> count stays 5.
REQ-039 ram_rd_valid with count 0 -> underflow_err=1, stays set until rst_n low.
REQ-040 NUM_CLIENTS=3, sel=3 (invalid) -> no DRAIN, switch_busy=0, owner unchanged.
